// File: rtl/tone_player_pkg.sv
// Shared constants, state encoding and half-period scaling for the tone player.
package tone_player_pkg;

  localparam int NOTE_BITS   = 3;
  localparam int OCTAVE_BITS = 2;
  localparam int LENGTH_BITS = 3;
  localparam int TONE_BITS   = 20;
  localparam int DUR_BITS    = 27;

  // Middle-octave half-periods in cycles of a 100 MHz clock, notes C..B.
  localparam int REF_CLK_HZ = 100_000_000;
  localparam int HALF_C = 190840;
  localparam int HALF_D = 170068;
  localparam int HALF_E = 151515;
  localparam int HALF_F = 143266;
  localparam int HALF_G = 127551;
  localparam int HALF_A = 113636;
  localparam int HALF_B = 101215;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Rescales a 100 MHz half-period to the actual clock; identity at 100 MHz.
  // Floored at 2 so the high-octave shift never yields a zero half-period.
  function automatic logic [TONE_BITS-1:0] scale_half(input longint base, input longint clk_hz);
    longint s;
    s = (base * clk_hz) / longint'(REF_CLK_HZ);
    if (s < 2) s = 2;
    return TONE_BITS'(s);
  endfunction

endpackage

// File: rtl/tone_player_tone_divider.sv
// Square-wave generator: toggles its output every 'half' enabled cycles.
module tone_divider
  import tone_player_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [TONE_BITS-1:0] half,
  input  logic                 en,
  output logic                 wave
);

  logic [TONE_BITS-1:0] cnt;

  // Count up to half-1 then toggle; disabling forces silence and restarts the phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      wave <= 1'b0;
    end else if (!en) begin
      cnt  <= '0;
      wave <= 1'b0;
    end else if (cnt == half - TONE_BITS'(1)) begin
      cnt  <= '0;
      wave <= ~wave;
    end else begin
      cnt <= cnt + TONE_BITS'(1);
    end
  end

endmodule

// File: rtl/tone_player.sv
// Plays one note per start request: timed tone, silent gap, then a done pulse.
//
// state | meaning
// IDLE  | waiting for start (stop blocks acceptance)
// PLAY  | tone (or rest) for (length+1) x UNIT_CYCLES cycles
// GAP   | forced silence for GAP_CYCLES cycles
// DONE  | one-cycle done pulse, busy already low
module tone_player
  import tone_player_pkg::*;
#(
  parameter int CLK_HZ      = 100_000_000,
  parameter int UNIT_CYCLES = 12_500_000,
  parameter int GAP_CYCLES  = 1_000_000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   stop,
  input  logic [OCTAVE_BITS-1:0] octave,
  input  logic [NOTE_BITS-1:0]   note,
  input  logic [LENGTH_BITS-1:0] length,
  output logic                   buzzer,
  output logic                   busy,
  output logic                   done,
  output logic [NOTE_BITS-1:0]   cur_note
);

  localparam logic [TONE_BITS-1:0] HP_1 = scale_half(longint'(HALF_C), longint'(CLK_HZ));
  localparam logic [TONE_BITS-1:0] HP_2 = scale_half(longint'(HALF_D), longint'(CLK_HZ));
  localparam logic [TONE_BITS-1:0] HP_3 = scale_half(longint'(HALF_E), longint'(CLK_HZ));
  localparam logic [TONE_BITS-1:0] HP_4 = scale_half(longint'(HALF_F), longint'(CLK_HZ));
  localparam logic [TONE_BITS-1:0] HP_5 = scale_half(longint'(HALF_G), longint'(CLK_HZ));
  localparam logic [TONE_BITS-1:0] HP_6 = scale_half(longint'(HALF_A), longint'(CLK_HZ));
  localparam logic [TONE_BITS-1:0] HP_7 = scale_half(longint'(HALF_B), longint'(CLK_HZ));
  localparam logic [DUR_BITS-1:0]  GAP_LOAD = DUR_BITS'(GAP_CYCLES - 1);

  state_t                 state;
  logic [OCTAVE_BITS-1:0] oct_q;
  logic [NOTE_BITS-1:0]   note_q;
  logic [DUR_BITS-1:0]    dur_cnt;
  logic [DUR_BITS-1:0]    dur_load;
  logic [TONE_BITS-1:0]   base_half;
  logic [TONE_BITS-1:0]   half;
  logic                   tone_en;

  // Worst case 8 x 12.5M = 100M fits in 27 bits; load is cycle count minus one.
  assign dur_load = (DUR_BITS'(length) + DUR_BITS'(1)) * DUR_BITS'(UNIT_CYCLES) - DUR_BITS'(1);

  // Middle-octave half-period of the latched note.
  always_comb begin
    base_half = HP_1;
    case (note_q)
      3'd2:    base_half = HP_2;
      3'd3:    base_half = HP_3;
      3'd4:    base_half = HP_4;
      3'd5:    base_half = HP_5;
      3'd6:    base_half = HP_6;
      3'd7:    base_half = HP_7;
      default: base_half = HP_1;
    endcase
  end

  // Octave shift: low doubles (max 381680 fits 20 bits), high halves.
  always_comb begin
    half = base_half;
    case (oct_q)
      2'd0:    half = base_half << 1;
      2'd1:    half = base_half;
      default: half = base_half >> 1;
    endcase
  end

  // Tone runs only in PLAY with a real note; dropping it on the last PLAY cycle
  // or on stop makes the buzzer register read 0 as soon as PLAY is left.
  assign tone_en = (state == ST_PLAY) && (note_q != '0) && !stop && (dur_cnt != '0);

  tone_divider u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .half  (half),
    .en    (tone_en),
    .wave  (buzzer)
  );

  // Sequencer: acceptance, duration/gap down-counting, completion and abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      oct_q    <= '0;
      note_q   <= '0;
      dur_cnt  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cur_note <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && !stop) begin
            oct_q    <= octave;
            note_q   <= note;
            dur_cnt  <= dur_load;
            busy     <= 1'b1;
            cur_note <= note;
            state    <= ST_PLAY;
          end
        end
        ST_PLAY, ST_GAP: begin
          if (stop) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            cur_note <= '0;
            note_q   <= '0;
            dur_cnt  <= '0;
          end else if (dur_cnt != '0) begin
            dur_cnt <= dur_cnt - DUR_BITS'(1);
          end else if (state == ST_PLAY) begin
            dur_cnt <= GAP_LOAD;
            state   <= ST_GAP;
          end else begin
            done     <= 1'b1;
            busy     <= 1'b0;
            cur_note <= '0;
            note_q   <= '0;
            state    <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
